dout_rr_arbiter: RTL and testbench

Round-robin arbiter that shares the single result-FIFO write port among N PIM bank output lanes. Each lane offers a word with a valid/ready handshake. The arbiter grants at most one lane per cycle, starting its search from the lane after the last winner, and registers the winning word onto the FIFO write interface. It honours FIFO backpressure, so no lane is starved and no word is dropped. The block sits between the bank DOUT lanes and the global-scheduler output FIFO.

---
 rtl/dout_rr_arbiter_if.sv | 31 +++
 rtl/dout_rr_arbiter.sv | 92 +++++++++
 tb/tb_dout_rr_arbiter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/dout_rr_arbiter_if.sv
// Lane-side and FIFO-side signals of the DOUT round-robin arbiter.
// The arbiter takes the slave modport; lanes/FIFO drive the master side.
interface dout_rr_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int CNT_W = 16
);
    localparam int ID_W = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]       in_valid;
    logic [WIDTH*N-1:0] in_data;
    logic [N-1:0]       in_ready;
    logic               fifo_full;
    logic [WIDTH-1:0]   fifo_data_in;
    logic               fifo_write_en;
    logic [ID_W-1:0]    grant_id;
    logic [CNT_W-1:0]   words_written;
    logic               busy;

    modport master (
        output in_valid, in_data, fifo_full,
        input  in_ready, fifo_data_in, fifo_write_en,
        input  grant_id, words_written, busy
    );

    modport slave (
        input  in_valid, in_data, fifo_full,
        output in_ready, fifo_data_in, fifo_write_en,
        output grant_id, words_written, busy
    );
endinterface

// File: rtl/dout_rr_arbiter.sv
// Round-robin arbiter sharing the result-FIFO write port among N DOUT lanes.
// The winning word is registered onto the FIFO; search starts after the last winner.
module dout_rr_arbiter #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int CNT_W = 16
) (
    input logic              clk,
    input logic              rst_n,
    dout_rr_arbiter_if.slave bus
);
    localparam int ID_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [ID_W-1:0] LAST = ID_W'(N - 1);
    localparam logic [ID_W:0]   NW   = (ID_W + 1)'(N);

    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [ID_W-1:0]  sel;
    logic             found;
    logic             grant;
    logic [WIDTH-1:0] win;
    logic [WIDTH-1:0] data_q, data_d;
    logic             we_q, we_d;
    logic [ID_W-1:0]  gid_q, gid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Walk lanes ptr, ptr+1, ... with wrap at N; first valid lane wins.
    always_comb begin : search
        logic [ID_W:0]   s;
        logic [ID_W-1:0] idx;
        sel   = '0;
        found = 1'b0;
        s     = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            s = {1'b0, ptr_q} + (ID_W + 1)'(k);
            if (s >= NW) s = s - NW;
            idx = s[ID_W-1:0];
            if (!found && bus.in_valid[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    assign grant = found & ~bus.fifo_full & rst_n;

    always_comb begin : mux
        win          = '0;
        bus.in_ready = '0;
        for (int k = 0; k < N; k++) begin
            if (sel == ID_W'(k)) begin
                win             = bus.in_data[k*WIDTH +: WIDTH];
                bus.in_ready[k] = grant;
            end
        end
    end

    always_comb begin : next_state
        ptr_d  = ptr_q;
        data_d = data_q;
        gid_d  = gid_q;
        we_d   = grant;
        cnt_d  = we_q ? cnt_q + CNT_W'(1) : cnt_q;
        if (grant) begin
            data_d = win;
            gid_d  = sel;
            ptr_d  = (sel == LAST) ? '0 : sel + ID_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q  <= '0;
            data_q <= '0;
            we_q   <= 1'b0;
            gid_q  <= '0;
            cnt_q  <= '0;
        end else begin
            ptr_q  <= ptr_d;
            data_q <= data_d;
            we_q   <= we_d;
            gid_q  <= gid_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.fifo_data_in  = data_q;
    assign bus.fifo_write_en = we_q;
    assign bus.grant_id      = gid_q;
    assign bus.words_written = cnt_q;
    assign bus.busy          = (|bus.in_valid) | we_q;
endmodule

// File: tb/tb_dout_rr_arbiter.sv
// Directed and randomized checks of dout_rr_arbiter against a lane-level model.
// A second N=1 instance covers the single-lane case.
module tb_dout_rr_arbiter;
    localparam int W  = 8;
    localparam int N  = 4;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dout_rr_arbiter_if #(.WIDTH(W), .N(N), .CNT_W(CW)) bus ();
    dout_rr_arbiter_if #(.WIDTH(W), .N(1), .CNT_W(16)) bus1 ();

    dout_rr_arbiter #(.WIDTH(W), .N(N), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    dout_rr_arbiter #(.WIDTH(W), .N(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    int total = 0;
    int bad = 0;

    logic [W-1:0] lane_d [N];
    int m_ptr = 0;
    bit m_we = 0;
    int m_data = 0;
    int m_gid = 0;
    int m_cnt = 0;
    int g;
    int gd;
    int wg[$];
    int wd[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input int p, input logic [N-1:0] v);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic cycle(input bit auto_mode);
        logic [W*N-1:0] flat;
        for (int d = 0; d < N; d++) flat[d*W +: W] = lane_d[d];
        bus.in_data = flat;
        @(negedge clk);
        g = (rst_n && !bus.fifo_full) ? pick(m_ptr, bus.in_valid) : -1;
        gd = (g >= 0) ? int'(lane_d[g]) : 0;
        chk("in_ready", 32'(bus.in_ready), (g >= 0) ? 32'(1 << g) : 32'd0);
        chk("busy", 32'(bus.busy), 32'((|bus.in_valid) || m_we));
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m_ptr = 0; m_we = 0; m_data = 0; m_gid = 0; m_cnt = 0;
        end else begin
            if (m_we) m_cnt = (m_cnt + 1) % (1 << CW);
            m_we = (g >= 0);
            if (g >= 0) begin
                m_data = gd;
                m_gid = g;
                m_ptr = (g + 1) % N;
            end
        end
        chk("write_en", 32'(bus.fifo_write_en), 32'(m_we));
        chk("data", 32'(bus.fifo_data_in), 32'(m_data));
        chk("grant_id", 32'(bus.grant_id), 32'(m_gid));
        chk("words", 32'(bus.words_written), 32'(m_cnt));
        if (bus.fifo_write_en === 1'b1) begin
            wg.push_back(int'(bus.grant_id));
            wd.push_back(int'(bus.fifo_data_in));
        end
        if (auto_mode) begin
            if (g >= 0) begin
                bus.in_valid[g] = 1'($urandom % 2);
                lane_d[g] = W'($urandom);
            end
            for (int d = 0; d < N; d++) begin
                if (!bus.in_valid[d] && d != g && ($urandom % 3) == 0) begin
                    bus.in_valid[d] = 1'b1;
                    lane_d[d] = W'($urandom);
                end
            end
            bus.fifo_full = (($urandom % 4) == 0);
        end
    endtask

    initial begin
        logic [W-1:0] n1d;
        bit g1;
        logic [W-1:0] g1d;

        for (int d = 0; d < N; d++) lane_d[d] = W'(8'hA0 + d);
        bus.in_valid = '1;
        bus.fifo_full = 1'b0;
        bus1.in_valid = '0;
        bus1.in_data = '0;
        bus1.fifo_full = 1'b0;

        // reset with all lanes requesting
        rst_n = 1'b0;
        repeat (3) cycle(0);
        chk("rst_we", 32'(bus.fifo_write_en), 32'd0);
        chk("rst_data", 32'(bus.fifo_data_in), 32'd0);
        chk("rst_gid", 32'(bus.grant_id), 32'd0);
        chk("rst_cnt", 32'(bus.words_written), 32'd0);
        rst_n = 1'b1;

        // round robin, all valid
        wg.delete(); wd.delete();
        repeat (5) cycle(0);
        chk("rr_len", 32'(wg.size()), 32'd5);
        for (int i = 0; i < 5 && i < wg.size(); i++) begin
            chk("rr_gid", 32'(wg[i]), 32'(i % 4));
            chk("rr_data", 32'(wd[i]), 32'(8'hA0 + (i % 4)));
        end

        // move ptr to 2, then sparse lanes 1 and 3
        bus.in_valid = 4'b0010;
        cycle(0);
        wg.delete(); wd.delete();
        bus.in_valid = 4'b1010;
        repeat (2) cycle(0);
        chk("sparse_len", 32'(wg.size()), 32'd2);
        if (wg.size() == 2) begin
            chk("sparse_first", 32'(wg[0]), 32'd3);
            chk("sparse_second", 32'(wg[1]), 32'd1);
        end

        // backpressure after the grant to lane 1
        wg.delete(); wd.delete();
        bus.in_valid = '1;
        repeat (4) cycle(0);
        bus.fifo_full = 1'b1;
        repeat (5) cycle(0);
        bus.fifo_full = 1'b0;
        cycle(0);
        chk("bp_len", 32'(wg.size()), 32'd5);
        if (wg.size() == 5) begin
            chk("bp_last_before", 32'(wg[3]), 32'd1);
            chk("bp_last_data", 32'(wd[3]), 32'hA1);
            chk("bp_release", 32'(wg[4]), 32'd2);
        end

        // counter wrap: 17 writes on a 4-bit counter
        rst_n = 1'b0;
        cycle(0);
        rst_n = 1'b1;
        bus.in_valid = '1;
        repeat (17) cycle(0);
        bus.in_valid = '0;
        cycle(0);
        chk("wrap_cnt", 32'(bus.words_written), 32'd1);
        chk("busy_drop", 32'(bus.busy), 32'd0);

        // randomized traffic with a mid-stream reset
        for (int i = 0; i < 300; i++) begin
            if (i == 150) rst_n = 1'b0;
            if (i == 151) rst_n = 1'b1;
            cycle(1);
        end

        // single-lane instance with fifo_full toggling
        bus.in_valid = '0;
        bus.fifo_full = 1'b0;
        n1d = 8'h10;
        bus1.in_valid = 1'b1;
        bus1.in_data = n1d;
        for (int i = 0; i < 12; i++) begin
            bus1.fifo_full = 1'(i % 2);
            @(negedge clk);
            g1 = !bus1.fifo_full;
            g1d = n1d;
            chk("n1_ready", 32'(bus1.in_ready), 32'(g1));
            @(posedge clk);
            #1;
            chk("n1_we", 32'(bus1.fifo_write_en), 32'(g1));
            chk("n1_gid", 32'(bus1.grant_id), 32'd0);
            if (g1) begin
                chk("n1_data", 32'(bus1.fifo_data_in), 32'(g1d));
                n1d = n1d + 8'd1;
                bus1.in_data = n1d;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
